// File: rtl/br_pred_two_level_gen_pkg.sv
// Shared types for the two-level branch direction predictor.
// Optional speculative history is enabled by RSD_BPRED_SPEC_HISTORY_EN.
package br_pred_two_level_gen_pkg;

  localparam int DEF_PHT_ENTRY_NUM = 2048;
  localparam int DEF_HISTORY_WIDTH = 5;

  typedef logic [1:0] PHT_Counter;
  typedef logic [$clog2(DEF_PHT_ENTRY_NUM)-1:0] PHT_Index;
  typedef logic [DEF_HISTORY_WIDTH-1:0] BranchHistory;

  localparam PHT_Counter PHT_INIT_VALUE = 2'd1;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } pred_state_e;

  function automatic PHT_Counter sat_update(
    input PHT_Counter c,
    input logic       taken
  );
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/br_pred_two_level_gen_pht_counter_array.sv
// PHT storage: FETCH_WIDTH async read ports, one write port.
// The init sweep takes priority over training writes.
import br_pred_two_level_gen_pkg::*;

module pht_counter_array #(
  parameter  int FETCH_WIDTH   = 2,
  parameter  int PHT_ENTRY_NUM = 2048,
  localparam int IW            = $clog2(PHT_ENTRY_NUM)
) (
  input  logic                            clk,
  input  logic                            init_i,
  input  logic [IW-1:0]                   init_idx_i,
  input  logic [FETCH_WIDTH-1:0][IW-1:0]  rd_idx_i,
  output PHT_Counter [FETCH_WIDTH-1:0]    rd_ctr_o,
  input  logic                            upd_i,
  input  logic                            upd_taken_i,
  input  logic [IW-1:0]                   upd_idx_i
);

  PHT_Counter mem_q [PHT_ENTRY_NUM];

  logic       we;
  logic [IW-1:0] waddr;
  PHT_Counter wdata;

  always_comb begin
    we    = init_i | upd_i;
    waddr = upd_idx_i;
    wdata = sat_update(mem_q[upd_idx_i], upd_taken_i);
    if (init_i) begin
      waddr = init_idx_i;
      wdata = PHT_INIT_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Reads see the pre-write value on a same-cycle hit.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rd_ctr_o[i] = mem_q[rd_idx_i[i]];
    end
  end

endmodule

// File: rtl/br_pred_two_level_gen.sv
// Two-level direction predictor: INIT/READY FSM, history regs.
// Define RSD_BPRED_SPEC_HISTORY_EN for speculative history + recovery.
import br_pred_two_level_gen_pkg::*;

module br_pred_two_level_gen #(
  parameter int FETCH_WIDTH   = 2,
  parameter int PHT_ENTRY_NUM = 2048,
  parameter int HISTORY_WIDTH = 5,
  parameter int SET_NUM       = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  output logic                                      ready,
  input  logic [FETCH_WIDTH-1:0]                    predValid,
  input  logic [FETCH_WIDTH-1:0][31:0]              predPC,
  output logic [FETCH_WIDTH-1:0]                    predTaken,
  output logic [FETCH_WIDTH-1:0][HISTORY_WIDTH-1:0] predHist,
  input  logic                                      updValid,
  input  logic                                      updTaken,
  input  logic [31:0]                               updPC,
  input  logic [HISTORY_WIDTH-1:0]                  updHist,
  input  logic                                      recValid,
  input  logic                                      recTaken,
  input  logic [31:0]                               recPC,
  input  logic [HISTORY_WIDTH-1:0]                  recHist
);

  localparam int IW = $clog2(PHT_ENTRY_NUM);
  localparam int SW = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
  localparam int LW = IW - HISTORY_WIDTH;

  typedef logic [HISTORY_WIDTH-1:0] hist_t;

  function automatic logic [SW-1:0] set_of(input logic [31:0] pc);
    return (SET_NUM > 1) ? pc[2 +: SW] : '0;
  endfunction

  function automatic logic [IW-1:0] idx_of(
    input logic [31:0] pc,
    input hist_t       h
  );
    logic [31:0] lo;
    logic [31:0] hi;
    lo = (pc >> 2) & ((32'd1 << LW) - 32'd1);
    hi = 32'(h) << LW;
    return IW'(hi | lo);
  endfunction

  pred_state_e   state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic          rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + IW'(1);
        if (init_cnt_q == IW'(PHT_ENTRY_NUM - 1)) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  assign rdy   = (state_q == ST_READY);
  assign ready = rdy;

  logic [SET_NUM-1:0][HISTORY_WIDTH-1:0]     hist_q, hist_d;
  logic [FETCH_WIDTH-1:0][IW-1:0]            rd_idx;
  PHT_Counter [FETCH_WIDTH-1:0]              rd_ctr;
  logic [FETCH_WIDTH-1:0]                    predTaken_q, predTaken_d;
  logic [FETCH_WIDTH-1:0][HISTORY_WIDTH-1:0] predHist_q, predHist_d;

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      predHist_d[i]  = hist_q[set_of(predPC[i])];
      rd_idx[i]      = idx_of(predPC[i], predHist_d[i]);
      predTaken_d[i] = rdy & predValid[i] & rd_ctr[i][1];
    end
  end

  pht_counter_array #(
    .FETCH_WIDTH   (FETCH_WIDTH),
    .PHT_ENTRY_NUM (PHT_ENTRY_NUM)
  ) u_pht (
    .clk         (clk),
    .init_i      (~rdy),
    .init_idx_i  (init_cnt_q),
    .rd_idx_i    (rd_idx),
    .rd_ctr_o    (rd_ctr),
    .upd_i       (rdy & updValid),
    .upd_taken_i (updTaken),
    .upd_idx_i   (idx_of(updPC, updHist))
  );

`ifdef RSD_BPRED_SPEC_HISTORY_EN
  localparam int LNW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  logic [FETCH_WIDTH-1:0]         pv_q;
  logic [FETCH_WIDTH-1:0][SW-1:0] pset_q;
  logic [LNW-1:0]                 lane;
  logic                           hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q   <= '0;
      pset_q <= '0;
    end else begin
      pv_q <= predValid;
      for (int i = 0; i < FETCH_WIDTH; i++) pset_q[i] <= set_of(predPC[i]);
    end
  end

  // Lowest taken lane wins; otherwise the highest valid lane.
  always_comb begin
    hist_d = hist_q;
    lane   = '0;
    hit    = 1'b0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (pv_q[i] && predTaken_q[i]) begin
        lane = LNW'(i);
        hit  = 1'b1;
      end
    end
    if (!hit) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (pv_q[i]) lane = LNW'(i);
      end
    end
    if (rdy && recValid) begin
      hist_d[set_of(recPC)] = {recHist[HISTORY_WIDTH-2:0], recTaken};
    end else if (rdy && |pv_q) begin
      hist_d[pset_q[lane]] =
        {hist_q[pset_q[lane]][HISTORY_WIDTH-2:0], predTaken_q[lane]};
    end
  end
`else
  always_comb begin
    hist_d = hist_q;
    if (rdy && updValid) begin
      hist_d[set_of(updPC)] =
        {hist_q[set_of(updPC)][HISTORY_WIDTH-2:0], updTaken};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q      <= '0;
      predTaken_q <= '0;
      predHist_q  <= '0;
    end else begin
      hist_q      <= hist_d;
      predTaken_q <= predTaken_d;
      predHist_q  <= predHist_d;
    end
  end

  assign predTaken = predTaken_q;
  assign predHist  = predHist_q;

  logic unused_bits;
  assign unused_bits = ^{predPC, updPC, recPC, recValid, recTaken, recHist};

endmodule

// File: tb/tb_br_pred_two_level_gen.sv
// Bench for br_pred_two_level_gen: reference model plus directed cases.
// Covers both RSD_BPRED_SPEC_HISTORY_EN builds.
module tb_br_pred_two_level_gen;

  localparam int FW = 2;
  localparam int PN = 2048;
  localparam int HW = 5;
  localparam int SN = 4;
  localparam int LW = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   ready;
  logic [FW-1:0]          predValid;
  logic [FW-1:0][31:0]    predPC;
  logic [FW-1:0]          predTaken;
  logic [FW-1:0][HW-1:0]  predHist;
  logic                   updValid, updTaken;
  logic [31:0]            updPC;
  logic [HW-1:0]          updHist;
  logic                   recValid, recTaken;
  logic [31:0]            recPC;
  logic [HW-1:0]          recHist;

  br_pred_two_level_gen #(
    .FETCH_WIDTH   (FW),
    .PHT_ENTRY_NUM (PN),
    .HISTORY_WIDTH (HW),
    .SET_NUM       (SN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .predValid (predValid),
    .predPC    (predPC),
    .predTaken (predTaken),
    .predHist  (predHist),
    .updValid  (updValid),
    .updTaken  (updTaken),
    .updPC     (updPC),
    .updHist   (updHist),
    .recValid  (recValid),
    .recTaken  (recTaken),
    .recPC     (recPC),
    .recHist   (recHist)
  );

  always #5 clk = ~clk;

  int nChk  = 0;
  int nPass = 0;

  task automatic chk(input string name, input int act, input int exp);
    nChk++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int m_set(input logic [31:0] pc);
    return int'((pc >> 2) % SN);
  endfunction

  function automatic int m_idx(input logic [31:0] pc, input int h);
    return h * (1 << LW) + int'((pc >> 2) % (1 << LW));
  endfunction

  int pht [PN];
  int hist [SN];
  int cnt;
  int eR;
  int eT [FW];
  int eH [FW];
  int pv [FW];
  int pt [FW];
  int ps [FW];

  always @(posedge clk or posedge rst) begin : mdl
    int rdy;
    int k;
    int s;
    int lane;
    int nt [FW];
    int nh [FW];
    int ns [FW];
    if (rst) begin
      foreach (pht[j]) pht[j] = 1;
      foreach (hist[j]) hist[j] = 0;
      cnt = 0;
      eR  = 0;
      for (int i = 0; i < FW; i++) begin
        eT[i] = 0; eH[i] = 0; pv[i] = 0; pt[i] = 0; ps[i] = 0;
      end
    end else begin
      rdy = (cnt >= PN) ? 1 : 0;
      for (int i = 0; i < FW; i++) begin
        ns[i] = m_set(predPC[i]);
        nh[i] = hist[ns[i]];
        nt[i] = (rdy == 1 && predValid[i] &&
                 pht[m_idx(predPC[i], nh[i])] >= 2) ? 1 : 0;
      end
      if (rdy == 1) begin
        if (updValid) begin
          k = m_idx(updPC, int'(updHist));
          if (updTaken) pht[k] = (pht[k] == 3) ? 3 : pht[k] + 1;
          else          pht[k] = (pht[k] == 0) ? 0 : pht[k] - 1;
        end
`ifdef RSD_BPRED_SPEC_HISTORY_EN
        if (recValid) begin
          hist[m_set(recPC)] = (int'(recHist) * 2 + int'(recTaken)) % (1 << HW);
        end else begin
          lane = -1;
          for (int i = 0; i < FW; i++)
            if (lane < 0 && pv[i] == 1 && pt[i] == 1) lane = i;
          if (lane < 0)
            for (int i = 0; i < FW; i++) if (pv[i] == 1) lane = i;
          if (lane >= 0)
            hist[ps[lane]] = (hist[ps[lane]] * 2 + pt[lane]) % (1 << HW);
        end
`else
        if (updValid) begin
          s = m_set(updPC);
          hist[s] = (hist[s] * 2 + int'(updTaken)) % (1 << HW);
        end
`endif
      end
      for (int i = 0; i < FW; i++) begin
        pv[i] = int'(predValid[i]);
        pt[i] = nt[i];
        ps[i] = ns[i];
        eT[i] = nt[i];
        eH[i] = nh[i];
      end
      if (cnt < PN) cnt++;
      eR = (cnt >= PN) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    chk("ready", int'(ready), eR);
    for (int i = 0; i < FW; i++) begin
      chk($sformatf("predTaken[%0d]", i), int'(predTaken[i]), eT[i]);
      chk($sformatf("predHist[%0d]", i), int'(predHist[i]), eH[i]);
    end
  end

  task automatic upd_cyc(input logic [31:0] pc, input int h, input logic t);
    updValid = 1'b1;
    updPC    = pc;
    updHist  = HW'(h);
    updTaken = t;
    @(negedge clk);
    updValid = 1'b0;
  endtask

  initial begin
    int expA [3];
    expA = '{0, 1, 1};
    predValid = '0; predPC = '0;
    updValid = 1'b0; updTaken = 1'b0; updPC = '0; updHist = '0;
    recValid = 1'b0; recTaken = 1'b0; recPC = '0; recHist = '0;

    repeat (3) @(negedge clk);
    chk("reset ready", int'(ready), 0);
    chk("reset predTaken", int'(predTaken), 0);
    chk("reset predHist", int'(predHist), 0);

    rst = 1'b0;
    predValid = 2'b11;
    predPC[0] = 32'h100;
    predPC[1] = 32'h104;
    repeat (2047) @(negedge clk);
    chk("ready low at 2047", int'(ready), 0);
    chk("predTaken in init", int'(predTaken), 0);
    @(negedge clk);
    chk("ready at 2048", int'(ready), 1);
    predValid = '0;
    @(negedge clk);

`ifndef RSD_BPRED_SPEC_HISTORY_EN
    repeat (5) upd_cyc(32'h110, 0, 1'b1);
    predValid = 2'b01;
    predPC[0] = 32'h100;
    for (int k = 0; k < 3; k++) begin
      upd_cyc(32'h100, 31, 1'b1);
      chk("train up predTaken", int'(predTaken[0]), expA[k]);
      chk("train up predHist", int'(predHist[0]), 31);
    end
    @(negedge clk);
    chk("saturate at 3", int'(predTaken[0]), 1);
    chk("model ctr max", pht[m_idx(32'h100, 31)], 3);

    predValid = '0;
    repeat (5) upd_cyc(32'h110, 0, 1'b0);
    predValid = 2'b01;
    for (int k = 0; k < 6; k++) begin
      upd_cyc(32'h100, 0, 1'b0);
      chk("train down predTaken", int'(predTaken[0]), 0);
    end
    chk("model ctr min", pht[m_idx(32'h100, 0)], 0);
    predValid = '0;
    @(negedge clk);

    upd_cyc(32'h4, 0, 1'b1);
`else
    upd_cyc(32'h120, 0, 1'b1);
    predValid = 2'b11;
    predPC[0] = 32'h100;
    predPC[1] = 32'h120;
    @(negedge clk);
    chk("spec lanes taken", int'(predTaken), 2);
    chk("spec hist lane0", int'(predHist[0]), 0);
    chk("spec hist lane1", int'(predHist[1]), 0);
    predValid = 2'b10;
    @(negedge clk);
    chk("spec lane1 taken", int'(predTaken), 2);
    predValid = 2'b01;
    recValid  = 1'b1;
    recPC     = 32'h100;
    recHist   = 5'b10110;
    recTaken  = 1'b0;
    @(negedge clk);
    chk("spec shift", int'(predHist[0]), 1);
    recValid = 1'b0;
    @(negedge clk);
    chk("recovery wins", int'(predHist[0]), 12);
    predValid = '0;
    recValid  = 1'b1;
    recPC     = 32'h4;
    recHist   = '0;
    recTaken  = 1'b1;
    @(negedge clk);
    recValid = 1'b0;
`endif
    predValid = 2'b11;
    predPC[0] = 32'h4;
    predPC[1] = 32'h8;
    @(negedge clk);
    chk("set1 history", int'(predHist[0]), 1);
    chk("set2 untouched", int'(predHist[1]), 0);

    updValid = 1'b1;
    updPC    = 32'h4;
    updHist  = '0;
    updTaken = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst ready drops", int'(ready), 0);
    chk("rst predHist", int'(predHist), 0);
    chk("rst predTaken", int'(predTaken), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("init ignores update", int'(predHist[0]), 0);
    updValid = 1'b0;
    repeat (2044) @(negedge clk);
    chk("ready after restart", int'(ready), 1);
    @(negedge clk);
    chk("reinit ctr", int'(predTaken[0]), 0);
    chk("reinit hist", int'(predHist[0]), 0);
    predValid = '0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
